// File: rtl/wfg_drive_pat_stream_buf_pkg.sv
// Shared constants and types for the drive_pat stream buffer.
package wfg_drive_pat_pkg;

    // Default word width: one bit per pattern channel.
    localparam int WFG_PAT_CHANNELS_DEFAULT = 32;

    // Default buffer depth in words.
    localparam int WFG_PAT_DEPTH_DEFAULT = 4;

    // One pattern word at the default channel count.
    typedef logic [WFG_PAT_CHANNELS_DEFAULT-1:0] pat_word_t;

endpackage

// File: rtl/wfg_drive_pat_stream_buf_if.sv
// AXI-Stream style word channel feeding the pattern buffer.
// Handshake: a word transfers in a cycle where tvalid and tready are both 1
// at the rising clock edge. The source holds tdata stable while tvalid is
// high and not yet accepted; tready never depends on tvalid.
interface wfg_drive_pat_stream_buf_if #(
    parameter int CHANNELS = 32
);
    logic [CHANNELS-1:0] tdata;
    logic                tvalid;
    logic                tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/wfg_drive_pat_stream_buf_fifo.sv
// Generic synchronous FIFO with flush. Push is ignored when full, pop is
// ignored when empty, flush overrides both. No read-through: a word written
// this cycle becomes visible at pop_data from the next cycle on.
module wfg_drive_pat_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wfg_drive_pat_stream_buf.sv
// Stream buffer in front of the drive_pat channels: words arrive on the
// stream, each core sync pops one into the output register, and an empty
// buffer at sync time raises a sticky underflow flag.
module wfg_drive_pat_stream_buf
    import wfg_drive_pat_pkg::*;
#(
    parameter int CHANNELS = WFG_PAT_CHANNELS_DEFAULT,
    parameter int DEPTH    = WFG_PAT_DEPTH_DEFAULT,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    wfg_drive_pat_stream_buf_if.slave wfg_axis,
    input  logic                wfg_core_sync_i,
    input  logic                ctrl_en_q_i,
    input  logic                cfg_uflow_hold_q_i,
    input  logic [CHANNELS-1:0] cfg_idle_q_i,
    input  logic                clr_underflow_i,
    output logic [CHANNELS-1:0] axis_data_ff_o,
    output logic                underflow_o,
    output logic [CW-1:0]       fill_level_o
);

    logic [CHANNELS-1:0] pop_data;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                uflow_evt;
    logic                flush;

    // Ready comes from registered state only; rst_n term keeps it low in reset.
    assign wfg_axis.tready = rst_n && ctrl_en_q_i && !full;
    assign push            = wfg_axis.tvalid && wfg_axis.tready;
    assign flush           = !ctrl_en_q_i;
    assign pop             = wfg_core_sync_i && ctrl_en_q_i && !empty;
    assign uflow_evt       = wfg_core_sync_i && ctrl_en_q_i && empty;
    assign fill_level_o    = count;

    wfg_drive_pat_fifo #(
        .WIDTH (CHANNELS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (wfg_axis.tdata),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Output word register: flush clears, pop loads, underflow applies policy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_data_ff_o <= '0;
        end else if (flush) begin
            axis_data_ff_o <= '0;
        end else if (pop) begin
            axis_data_ff_o <= pop_data;
        end else if (uflow_evt && !cfg_uflow_hold_q_i) begin
            axis_data_ff_o <= cfg_idle_q_i;
        end
    end

    // Sticky underflow flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_o <= 1'b0;
        end else if (uflow_evt) begin
            underflow_o <= 1'b1;
        end else if (clr_underflow_i) begin
            underflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wfg_drive_pat_stream_buf.sv
// Directed bench for the drive_pat stream buffer.
module tb_wfg_drive_pat_stream_buf;
    import wfg_drive_pat_pkg::*;

    localparam int CHANNELS = 32;
    localparam int DEPTH    = 4;
    localparam int CW       = $clog2(DEPTH) + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wfg_drive_pat_stream_buf_if #(.CHANNELS(CHANNELS)) axis_if ();

    logic                wfg_core_sync_i;
    logic                ctrl_en_q_i;
    logic                cfg_uflow_hold_q_i;
    logic [CHANNELS-1:0] cfg_idle_q_i;
    logic                clr_underflow_i;
    logic [CHANNELS-1:0] axis_data_ff_o;
    logic                underflow_o;
    logic [CW-1:0]       fill_level_o;

    int checks   = 0;
    int failures = 0;

    pat_word_t words [5];

    wfg_drive_pat_stream_buf #(
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .wfg_axis           (axis_if),
        .wfg_core_sync_i    (wfg_core_sync_i),
        .ctrl_en_q_i        (ctrl_en_q_i),
        .cfg_uflow_hold_q_i (cfg_uflow_hold_q_i),
        .cfg_idle_q_i       (cfg_idle_q_i),
        .clr_underflow_i    (clr_underflow_i),
        .axis_data_ff_o     (axis_data_ff_o),
        .underflow_o        (underflow_o),
        .fill_level_o       (fill_level_o)
    );

    // Advance one clock; inputs set before this are sampled at the edge,
    // outputs are read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] data, input logic [31:0] fill,
                             input logic uf, input logic rdy);
        check({tag, ".data"}, axis_data_ff_o, data);
        check({tag, ".fill"}, 32'(fill_level_o), fill);
        check({tag, ".uflow"}, 32'(underflow_o), 32'(uf));
        check({tag, ".tready"}, 32'(axis_if.tready), 32'(rdy));
    endtask

    task automatic push_word(input logic [31:0] w);
        axis_if.tvalid = 1'b1;
        axis_if.tdata  = w;
        step();
        axis_if.tvalid = 1'b0;
    endtask

    task automatic sync_pulse();
        wfg_core_sync_i = 1'b1;
        step();
        wfg_core_sync_i = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_underflow_i = 1'b1;
        step();
        clr_underflow_i = 1'b0;
    endtask

    initial begin
        words[0] = 32'h1111_0000;
        words[1] = 32'h2222_0001;
        words[2] = 32'h3333_0002;
        words[3] = 32'h4444_0003;
        words[4] = 32'h5555_0004;

        axis_if.tdata      = '0;
        axis_if.tvalid     = 1'b0;
        wfg_core_sync_i    = 1'b0;
        ctrl_en_q_i        = 1'b1;
        cfg_uflow_hold_q_i = 1'b0;
        cfg_idle_q_i       = '0;
        clr_underflow_i    = 1'b0;

        // Reset state (enable already high: tready must still be 0)
        #12;
        check_out("reset", 32'h0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check_out("post_reset", 32'h0, 0, 1'b0, 1'b1);

        // 1: two words, two syncs
        push_word(32'hA5A5_0001);
        check("t1.fill1", 32'(fill_level_o), 1);
        push_word(32'h0000_FFFF);
        check("t1.fill2", 32'(fill_level_o), 2);
        check("t1.data_before_sync", axis_data_ff_o, 32'h0);
        sync_pulse();
        check_out("t1.pop1", 32'hA5A5_0001, 1, 1'b0, 1'b1);
        sync_pulse();
        check_out("t1.pop2", 32'h0000_FFFF, 0, 1'b0, 1'b1);

        // 2: fill to DEPTH with tvalid held, then pop under back-pressure
        axis_if.tvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            axis_if.tdata = words[i];
            step();
        end
        axis_if.tdata = words[4];
        check("t2.full_fill", 32'(fill_level_o), 4);
        check("t2.full_tready", 32'(axis_if.tready), 0);
        wfg_core_sync_i = 1'b1;
        step();
        wfg_core_sync_i = 1'b0;
        check_out("t2.pop_full", words[0], 3, 1'b0, 1'b1);
        step();
        axis_if.tvalid = 1'b0;
        check_out("t2.refill", words[0], 4, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            sync_pulse();
            check("t2.drain.data", axis_data_ff_o, words[i]);
            check("t2.drain.fill", 32'(fill_level_o), 32'(4 - i));
        end

        // 3: underflow with idle load, then with hold
        cfg_uflow_hold_q_i = 1'b0;
        cfg_idle_q_i       = 32'h0F0F_0F0F;
        sync_pulse();
        check_out("t3.uflow_idle", 32'h0F0F_0F0F, 0, 1'b1, 1'b1);
        clr_pulse();
        check("t3.clr", 32'(underflow_o), 0);
        cfg_uflow_hold_q_i = 1'b1;
        cfg_idle_q_i       = 32'h1234_5678;
        sync_pulse();
        check_out("t3.uflow_hold", 32'h0F0F_0F0F, 0, 1'b1, 1'b1);
        clr_pulse();
        check("t3.clr2", 32'(underflow_o), 0);

        // 4: simultaneous push and pop
        push_word(32'hCAFE_0000);
        push_word(32'hCAFE_0001);
        axis_if.tvalid  = 1'b1;
        axis_if.tdata   = 32'hCAFE_0002;
        wfg_core_sync_i = 1'b1;
        step();
        axis_if.tvalid  = 1'b0;
        wfg_core_sync_i = 1'b0;
        check_out("t4.push_pop", 32'hCAFE_0000, 2, 1'b0, 1'b1);
        sync_pulse();
        check("t4.pop_b", axis_data_ff_o, 32'hCAFE_0001);
        sync_pulse();
        check_out("t4.pop_c", 32'hCAFE_0002, 0, 1'b0, 1'b1);
        // push + sync on an empty FIFO is an underflow; the word stays stored
        cfg_uflow_hold_q_i = 1'b0;
        cfg_idle_q_i       = 32'h0F0F_0F0F;
        axis_if.tvalid     = 1'b1;
        axis_if.tdata      = 32'hBEEF_0001;
        wfg_core_sync_i    = 1'b1;
        step();
        axis_if.tvalid     = 1'b0;
        wfg_core_sync_i    = 1'b0;
        check_out("t4.nobypass", 32'h0F0F_0F0F, 1, 1'b1, 1'b1);
        sync_pulse();
        check_out("t4.late_pop", 32'hBEEF_0001, 0, 1'b1, 1'b1);
        clr_pulse();
        check("t4.clr", 32'(underflow_o), 0);

        // 5: one-cycle disable mid-stream, sync ignored while disabled
        push_word(32'hDEAD_0001);
        push_word(32'hDEAD_0002);
        sync_pulse();
        check("t5.pre_data", axis_data_ff_o, 32'hDEAD_0001);
        ctrl_en_q_i     = 1'b0;
        wfg_core_sync_i = 1'b1;
        step();
        wfg_core_sync_i = 1'b0;
        check_out("t5.disabled", 32'h0, 0, 1'b0, 1'b0);
        ctrl_en_q_i = 1'b1;
        step();
        check("t5.reenable_tready", 32'(axis_if.tready), 1);
        // set and clear together: set wins
        wfg_core_sync_i = 1'b1;
        clr_underflow_i = 1'b1;
        step();
        wfg_core_sync_i = 1'b0;
        clr_underflow_i = 1'b0;
        check("t5.set_wins", 32'(underflow_o), 1);
        // disable holds the flag
        ctrl_en_q_i = 1'b0;
        step();
        check("t5.disable_holds_flag", 32'(underflow_o), 1);
        // clear still works while disabled
        clr_pulse();
        check("t5.clr_while_off", 32'(underflow_o), 0);
        ctrl_en_q_i = 1'b1;

        // 6: asynchronous reset between pushes
        cfg_uflow_hold_q_i = 1'b1;
        push_word(32'h5A5A_0001);
        sync_pulse();
        sync_pulse();
        push_word(32'h5A5A_0002);
        check_out("t6.pre_reset", 32'h5A5A_0001, 1, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_out("t6.async_reset", 32'h0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check_out("t6.released", 32'h0, 0, 1'b0, 1'b1);
        sync_pulse();
        check_out("t6.first_sync_uflow", 32'h0, 0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
